// File: rtl/tone_player.sv
// tone_player: queued melody engine driving the piezo beeper pin.
// Notes {period, dur, vol} enter a FIFO over valid/ready and are played
// back-to-back as a PWM tone.
// Optional feature: define TONE_PLAYER_GAP_EN to insert GAP silent cycles
// after every note.
module tone_player #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DUR_WIDTH = 24,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned GAP       = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     note_valid,
   output logic                     note_ready,
   input  logic [WIDTH-1:0]         note_period,
   input  logic [DUR_WIDTH-1:0]     note_dur,
   input  logic [1:0]               note_vol,
   input  logic                     flush,
   output logic                     beeper,
   output logic                     busy,
   output logic                     note_done,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned EW = WIDTH + DUR_WIDTH + 2;
`ifdef TONE_PLAYER_GAP_EN
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
`endif

   // Reject parameter sets the pointer arithmetic and gap counter cannot handle
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH < 2 || DUR_WIDTH < 1 || GAP < 1) begin : g_bad_param
      $error("tone_player: unsupported parameter set");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1
`ifdef TONE_PLAYER_GAP_EN
      ,
      S_GAP  = 2'd2
`endif
   } state_t;

   state_t                 state;
   logic [EW-1:0]          mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [WIDTH-1:0]       period_r;
   logic [WIDTH-1:0]       duty_r;
   logic [WIDTH-1:0]       cnt;
   logic [DUR_WIDTH-1:0]   rem;
`ifdef TONE_PLAYER_GAP_EN
   logic [GW-1:0]          gap_cnt;
`endif

   logic [WIDTH-1:0]       head_period;
   logic [WIDTH-1:0]       head_duty;
   logic [DUR_WIDTH-1:0]   head_dur;
   logic [DUR_WIDTH-1:0]   head_rem;
   logic [1:0]             head_vol;
   logic [WIDTH:0]         cnt_inc;
   logic [WIDTH-1:0]       cnt_nxt;
   logic                   empty_c;
   logic                   full_c;
   logic                   push_c;
   logic                   pop_c;
   logic                   note_end_c;
   logic                   slot_end_c;

   // High-time in clocks for a period/volume pair; rests and mute give 0
   function automatic logic [WIDTH-1:0] duty_of(input logic [WIDTH-1:0] p,
                                                input logic [1:0]       v);
      logic [WIDTH-1:0] d;
      d = '0;
      if (p >= WIDTH'(2)) begin
         case (v)
            2'd0:    d = p >> 1;
            2'd1:    d = p >> 2;
            2'd2:    d = p >> 3;
            default: d = '0;
         endcase
      end
      return d;
   endfunction

   // Handshake, FIFO head decode and tone counter wrap
   always_comb begin
      empty_c    = (level == '0);
      full_c     = (level == LW'(DEPTH));
      note_ready = !full_c && !flush;
      busy       = (state != S_IDLE) || !empty_c;
      push_c     = note_valid && note_ready;

      {head_period, head_dur, head_vol} = mem[rd_ptr];
      head_duty = duty_of(head_period, head_vol);
      head_rem  = (head_dur == '0) ? '0 : head_dur - DUR_WIDTH'(1);

      cnt_inc = {1'b0, cnt} + (WIDTH + 1)'(1);
      cnt_nxt = (cnt_inc >= {1'b0, period_r}) ? '0 : cnt_inc[WIDTH-1:0];

      note_end_c = (state == S_PLAY) && (rem == '0);
`ifdef TONE_PLAYER_GAP_EN
      slot_end_c = (state == S_GAP) && (gap_cnt == '0);
`else
      slot_end_c = note_end_c;
`endif
      pop_c = !flush && !empty_c && ((state == S_IDLE) || slot_end_c);
   end

   // Note storage; contents need no reset since level gates every read
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= {note_period, note_dur, note_vol};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_c, pop_c})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Player FSM; beeper and note_done are computed one edge ahead so they
   // come straight from flops yet match the current cnt/rem values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         period_r  <= '0;
         duty_r    <= '0;
         cnt       <= '0;
         rem       <= '0;
         beeper    <= 1'b0;
         note_done <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
         gap_cnt   <= '0;
`endif
      end else if (flush) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rem       <= '0;
         beeper    <= 1'b0;
         note_done <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
         gap_cnt   <= '0;
`endif
      end else if (pop_c) begin
         state     <= S_PLAY;
         period_r  <= head_period;
         duty_r    <= head_duty;
         cnt       <= '0;
         rem       <= head_rem;
         beeper    <= (head_duty != '0);
         note_done <= (head_rem == '0);
      end else begin
         case (state)
            S_IDLE: begin
               beeper    <= 1'b0;
               note_done <= 1'b0;
            end
            S_PLAY: begin
               if (note_end_c) begin
                  cnt       <= '0;
                  beeper    <= 1'b0;
                  note_done <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
                  state     <= S_GAP;
                  gap_cnt   <= GW'(GAP - 1);
`else
                  state     <= S_IDLE;
`endif
               end else begin
                  cnt       <= cnt_nxt;
                  rem       <= rem - DUR_WIDTH'(1);
                  beeper    <= (cnt_nxt < duty_r);
                  note_done <= (rem == DUR_WIDTH'(1));
               end
            end
`ifdef TONE_PLAYER_GAP_EN
            S_GAP: begin
               beeper    <= 1'b0;
               note_done <= 1'b0;
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
`endif
            default: begin
               state     <= S_IDLE;
               beeper    <= 1'b0;
               note_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tone_player.sv
// Directed testbench for tone_player (DEPTH=4 instance). Honours
// TONE_PLAYER_GAP_EN when checking note spacing.
module tb_tone_player;

   localparam int unsigned W    = 16;
   localparam int unsigned DW   = 24;
   localparam int unsigned DEP  = 4;
   localparam int unsigned GAPV = 4096;
`ifdef TONE_PLAYER_GAP_EN
   localparam int GAPC = GAPV;
`else
   localparam int GAPC = 0;
`endif

   logic          clk;
   logic          rst;
   logic          note_valid;
   logic          note_ready;
   logic [W-1:0]  note_period;
   logic [DW-1:0] note_dur;
   logic [1:0]    note_vol;
   logic          flush;
   logic          beeper;
   logic          busy;
   logic          note_done;
   logic [2:0]    level;

   int checks;
   int failures;

   tone_player #(.WIDTH(W), .DUR_WIDTH(DW), .DEPTH(DEP), .GAP(GAPV)) dut (
      .clk         (clk),
      .rst         (rst),
      .note_valid  (note_valid),
      .note_ready  (note_ready),
      .note_period (note_period),
      .note_dur    (note_dur),
      .note_vol    (note_vol),
      .flush       (flush),
      .beeper      (beeper),
      .busy        (busy),
      .note_done   (note_done),
      .level       (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer a note on the input bus
   task automatic present(input int p, input int d, input int v);
      note_valid  = 1'b1;
      note_period = W'(p);
      note_dur    = DW'(d);
      note_vol    = 2'(v);
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (beeper !== 1'b0)     begin failures++; $display("FAIL reset_beeper got=%0b exp=0", beeper); end
      checks++; if (note_done !== 1'b0)  begin failures++; $display("FAIL reset_note_done got=%0b exp=0", note_done); end
      checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (level !== 3'd0)      begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", note_ready); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL post_reset_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_single_note;
      logic eb, ed;
      present(8, 20, 0);
      @(negedge clk);
      note_valid = 1'b0;
      checks++; if (level !== 3'd1)  begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
      checks++; if (beeper !== 1'b0) begin failures++; $display("FAIL single_pre_beeper got=%0b exp=0", beeper); end
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         eb = ((i % 8) < 4);
         ed = (i == 19);
         checks++; if (beeper !== eb)    begin failures++; $display("FAIL single_beeper cyc=%0d got=%0b exp=%0b", i, beeper, eb); end
         checks++; if (note_done !== ed) begin failures++; $display("FAIL single_done cyc=%0d got=%0b exp=%0b", i, note_done, ed); end
         @(negedge clk);
      end
      checks++; if (beeper !== 1'b0)    begin failures++; $display("FAIL single_end_beeper got=%0b exp=0", beeper); end
      checks++; if (note_done !== 1'b0) begin failures++; $display("FAIL single_end_done got=%0b exp=0", note_done); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL single_end_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_volume;
      int highs;
      int exp_h;
      for (int v = 0; v < 4; v++) begin
         present(16, 32, v);
         @(negedge clk);
         note_valid = 1'b0;
         @(negedge clk);
         highs = 0;
         for (int i = 0; i < 32; i++) begin
            highs += int'(beeper);
            @(negedge clk);
         end
         exp_h = (v == 0) ? 16 : (v == 1) ? 8 : (v == 2) ? 4 : 0;
         checks++; if (highs != exp_h) begin failures++; $display("FAIL volume_highs vol=%0d got=%0d exp=%0d", v, highs, exp_h); end
         checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL volume_busy vol=%0d got=%0b exp=0", v, busy); end
      end
   endtask

   task automatic test_rest;
      logic eb;
      present(1, 0, 0);
      @(negedge clk);
      note_valid = 1'b0;
      @(negedge clk);
      checks++; if (beeper !== 1'b0)    begin failures++; $display("FAIL rest_beeper got=%0b exp=0", beeper); end
      checks++; if (note_done !== 1'b1) begin failures++; $display("FAIL rest_done got=%0b exp=1", note_done); end
      checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL rest_busy got=%0b exp=1", busy); end
      @(negedge clk);
      checks++; if (note_done !== 1'b0) begin failures++; $display("FAIL rest_done_after got=%0b exp=0", note_done); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rest_busy_after got=%0b exp=0", busy); end
      // period 3, vol 0 -> duty 1
      present(3, 6, 0);
      @(negedge clk);
      note_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         eb = ((i % 3) == 0);
         checks++; if (beeper !== eb) begin failures++; $display("FAIL period3_beeper cyc=%0d got=%0b exp=%0b", i, beeper, eb); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int c, k, ndone, extra, budget;
      int done_t[6];
      logic r, saw_full;
      c = 0; k = 0; ndone = 0; saw_full = 1'b0;
      budget = 300 + 7 * GAPC;
      while (ndone < 6 && c < budget) begin
         if (k < 6) present(2, 5 + 2 * k, 0);
         else       note_valid = 1'b0;
         r = note_ready;
         if (level == 3'(DEP)) begin
            saw_full = 1'b1;
            checks++; if (r !== 1'b0) begin failures++; $display("FAIL fill_ready_full cyc=%0d got=%0b exp=0", c, r); end
         end else begin
            checks++; if (r !== 1'b1) begin failures++; $display("FAIL fill_ready_free cyc=%0d lvl=%0d got=%0b exp=1", c, level, r); end
         end
         if (note_done === 1'b1) begin
            done_t[ndone] = c;
            ndone++;
         end
         @(negedge clk);
         c++;
         if (k < 6 && r) k++;
      end
      note_valid = 1'b0;
      checks++; if (ndone != 6)  begin failures++; $display("FAIL fill_done_count got=%0d exp=6", ndone); end
      checks++; if (k != 6)      begin failures++; $display("FAIL fill_accepted got=%0d exp=6", k); end
      checks++; if (!saw_full)   begin failures++; $display("FAIL fill_reached_full got=0 exp=1"); end
      if (ndone == 6) begin
         checks++; if (done_t[0] != 6) begin failures++; $display("FAIL fill_first_done got=%0d exp=6", done_t[0]); end
         for (int i = 1; i < 6; i++) begin
            checks++;
            if (done_t[i] - done_t[i-1] != 5 + 2 * i + GAPC) begin
               failures++;
               $display("FAIL fill_spacing note=%0d got=%0d exp=%0d", i, done_t[i] - done_t[i-1], 5 + 2 * i + GAPC);
            end
         end
      end
      extra = 0;
      for (int i = 0; i < GAPC + 10; i++) begin
         if (note_done === 1'b1) extra++;
         @(negedge clk);
      end
      checks++; if (extra != 0)     begin failures++; $display("FAIL fill_extra_done got=%0d exp=0", extra); end
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL fill_end_busy got=%0b exp=0", busy); end
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL fill_end_level got=%0d exp=0", level); end
   endtask

   task automatic test_flush;
      int nd, highs;
      present(8, 40, 0);
      @(negedge clk);
      present(8, 40, 1);
      @(negedge clk);
      present(8, 40, 2);
      @(negedge clk);
      note_valid = 1'b0;
      checks++; if (level !== 3'd2) begin failures++; $display("FAIL flush_pre_level got=%0d exp=2", level); end
      repeat (6) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%0b exp=1", busy); end
      flush = 1'b1;
      present(8, 10, 0);
      #1;
      checks++; if (note_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", note_ready); end
      @(negedge clk);
      flush = 1'b0;
      note_valid = 1'b0;
      checks++; if (beeper !== 1'b0)    begin failures++; $display("FAIL flush_beeper got=%0b exp=0", beeper); end
      checks++; if (level !== 3'd0)     begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
      checks++; if (note_done !== 1'b0) begin failures++; $display("FAIL flush_done got=%0b exp=0", note_done); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL flush_busy got=%0b exp=0", busy); end
      nd = 0; highs = 0;
      for (int i = 0; i < 60; i++) begin
         nd    += int'(note_done);
         highs += int'(beeper);
         @(negedge clk);
      end
      checks++; if (nd != 0)        begin failures++; $display("FAIL flush_later_done got=%0d exp=0", nd); end
      checks++; if (highs != 0)     begin failures++; $display("FAIL flush_later_beeper got=%0d exp=0", highs); end
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_later_level got=%0d exp=0", level); end
   endtask

   task automatic test_reset_mid_note;
      present(4, 50, 0);
      @(negedge clk);
      present(4, 50, 0);
      @(negedge clk);
      present(4, 50, 0);
      @(negedge clk);
      note_valid = 1'b0;
      checks++; if (beeper !== 1'b1) begin failures++; $display("FAIL rstmid_pre_beeper got=%0b exp=1", beeper); end
      checks++; if (level !== 3'd2)  begin failures++; $display("FAIL rstmid_pre_level got=%0d exp=2", level); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (beeper !== 1'b0)    begin failures++; $display("FAIL rstmid_beeper got=%0b exp=0", beeper); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
      checks++; if (level !== 3'd0)     begin failures++; $display("FAIL rstmid_level got=%0d exp=0", level); end
      checks++; if (note_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%0b exp=0", note_done); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle_busy got=%0b exp=0", busy); end
      present(4, 4, 0);
      @(negedge clk);
      note_valid = 1'b0;
      @(negedge clk);
      checks++; if (beeper !== 1'b1) begin failures++; $display("FAIL rstmid_resume_beeper got=%0b exp=1", beeper); end
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rstmid_resume_busy got=%0b exp=0", busy); end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      note_valid  = 1'b0;
      note_period = '0;
      note_dur    = '0;
      note_vol    = '0;
      flush       = 1'b0;
      test_reset();
      test_single_note();
      test_volume();
      test_rest();
      test_back_to_back();
      test_flush();
      test_reset_mid_note();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound in case the design stalls
   initial begin
      #3000000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
